four_in_or_checker: RTL and testbench



---
 rtl/four_in_or_checker_if.sv | 14 +
 rtl/four_in_or_checker.sv | 108 ++++++++++
 tb/tb_four_in_or_checker.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/four_in_or_checker_if.sv
// Stimulus/response bus between the OR-gate checker and the four-input OR gate.
// The checker drives a..d and samples the gate's e, f, g responses.
interface four_in_or_checker_if;
  logic a;
  logic b;
  logic c;
  logic d;
  logic e;
  logic f;
  logic g;

  modport master (output a, b, c, d, input e, f, g);
  modport slave  (input a, b, c, d, output e, f, g);
endinterface

// File: rtl/four_in_or_checker.sv
// Clocked self-test for the four-input OR gate: walks all 16 input vectors,
// compares e/f/g against the expected ORs and reports error count, first failure and pass.
module four_in_or_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  four_in_or_checker_if.master        bus,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [4:0]                  err_count,
  output logic                        first_fail_valid,
  output logic [3:0]                  first_fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, DONE} state_t;

  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES);

  state_t      state_q;
  logic [3:0]  vec_q;
  logic [7:0]  settleCnt_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [4:0]  errCount_q;
  logic        firstFailValid_q;
  logic [3:0]  firstFailVec_q;

  logic [2:0]  expected_d;
  logic        mismatch_d;
  logic [4:0]  errCount_d;

  // One error per failing vector, no matter how many of e/f/g disagree
  assign expected_d = {vec_q[3] | vec_q[2], vec_q[1] | vec_q[0], |vec_q};
  assign mismatch_d = ({bus.e, bus.f, bus.g} != expected_d);
  assign errCount_d = errCount_q + 5'(mismatch_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      vec_q            <= 4'd0;
      settleCnt_q      <= 8'd0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      errCount_q       <= 5'd0;
      firstFailValid_q <= 1'b0;
      firstFailVec_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q          <= SETTLE;
            vec_q            <= 4'd0;
            settleCnt_q      <= SettleLoad;
            busy_q           <= 1'b1;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            errCount_q       <= 5'd0;
            firstFailValid_q <= 1'b0;
            firstFailVec_q   <= 4'd0;
          end
        end
        SETTLE: begin
          // Leaving on count 1 gives exactly SETTLE_CYCLES cycles of settling
          if (settleCnt_q <= 8'd1) begin
            state_q <= COMPARE;
          end else begin
            settleCnt_q <= settleCnt_q - 8'd1;
          end
        end
        COMPARE: begin
          errCount_q <= errCount_d;
          if (mismatch_d && !firstFailValid_q) begin
            firstFailValid_q <= 1'b1;
            firstFailVec_q   <= vec_q;
          end
          if (vec_q == 4'd15) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (errCount_d == 5'd0);
          end else begin
            state_q     <= SETTLE;
            vec_q       <= vec_q + 4'd1;
            settleCnt_q <= SettleLoad;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a            = vec_q[3];
  assign bus.b            = vec_q[2];
  assign bus.c            = vec_q[1];
  assign bus.d            = vec_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = errCount_q;
  assign first_fail_valid = firstFailValid_q;
  assign first_fail_vec   = firstFailVec_q;

endmodule

// File: tb/tb_four_in_or_checker.sv
// Bench for four_in_or_checker: a behavioural OR gate with selectable faults sits on the bus,
// and expected run results go through a scoreboard queue checked when done rises.
module tb_four_in_or_checker;

  localparam int SETTLE = 2;
  localparam int PERIOD = SETTLE + 1;
  localparam int RUN    = 16 * PERIOD;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic       first_fail_valid;
  logic [3:0] first_fail_vec;
  logic [3:0] abcd;
  int         faultMode;
  int         passCount = 0;
  int         totalCount = 0;

  four_in_or_checker_if bus ();

  four_in_or_checker #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .bus              (bus),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec)
  );

  // Gate model: 0 = correct, 1 = g stuck at 0, 2 = f inverted only on vector 5
  assign abcd  = {bus.a, bus.b, bus.c, bus.d};
  assign bus.e = bus.a | bus.b;
  assign bus.f = (bus.c | bus.d) ^ ((faultMode == 2) && (abcd == 4'd5));
  assign bus.g = (faultMode == 1) ? 1'b0 : (|abcd);

  always #5 clk = ~clk;

  typedef struct {
    int         fault;
    bit         midStart;
    logic [4:0] err;
    logic       ffv;
    logic [3:0] ffvec;
    logic       pass;
  } runVec_t;

  typedef struct {
    logic [4:0] err;
    logic       ffv;
    logic [3:0] ffvec;
    logic       pass;
    int         len;
  } expRes_t;

  expRes_t sbQ[$];
  runVec_t runTable[6];

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, watch the vector walk, then pop the expected result when done rises
  task automatic applyStimulus(input runVec_t rv);
    expRes_t exp;
    expRes_t got;
    int k;
    int stimErr;
    int busyErr;
    exp.err   = rv.err;
    exp.ffv   = rv.ffv;
    exp.ffvec = rv.ffvec;
    exp.pass  = rv.pass;
    exp.len   = RUN;
    sbQ.push_back(exp);
    faultMode = rv.fault;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("startClear", {busy, done, pass, err_count, first_fail_valid, abcd},
                {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0});
    k = 0;
    stimErr = 0;
    busyErr = 0;
    while (!done && k < RUN + 20) begin
      if (abcd != 4'(k / PERIOD)) stimErr++;
      if (!busy) busyErr++;
      start = rv.midStart && (k == 3 * PERIOD);
      tick();
      k++;
    end
    start = 1'b0;
    got = sbQ.pop_front();
    checkOutput("runLength", k, got.len);
    checkOutput("stimSeq", stimErr, 0);
    checkOutput("busyDuringRun", busyErr, 0);
    checkOutput("errCount", err_count, got.err);
    checkOutput("firstFailValid", first_fail_valid, got.ffv);
    checkOutput("firstFailVec", first_fail_vec, got.ffvec);
    checkOutput("pass", pass, got.pass);
    checkOutput("busyAtDone", busy, 0);
    repeat (3) tick();
    checkOutput("doneHold", {done, abcd, err_count}, {1'b1, 4'hF, got.err});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    runTable[0] = '{0, 1'b0, 5'd0,  1'b0, 4'd0, 1'b1};
    runTable[1] = '{1, 1'b0, 5'd15, 1'b1, 4'd1, 1'b0};
    runTable[2] = '{2, 1'b0, 5'd1,  1'b1, 4'd5, 1'b0};
    runTable[3] = '{0, 1'b1, 5'd0,  1'b0, 4'd0, 1'b1};
    runTable[4] = '{1, 1'b1, 5'd15, 1'b1, 4'd1, 1'b0};
    runTable[5] = '{0, 1'b0, 5'd0,  1'b0, 4'd0, 1'b1};

    faultMode = 0;
    rst = 1'b1;
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    checkOutput("resetState", {abcd, busy, done, pass, err_count, first_fail_valid, first_fail_vec}, 0);
    repeat (3) tick();
    checkOutput("idleHold", {busy, done, abcd}, 0);

    for (int i = 0; i < 6; i++) applyStimulus(runTable[i]);

    // Reset in the middle of a faulty run, at vector 7, after six errors have accrued
    faultMode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7 * PERIOD) tick();
    checkOutput("preResetVec", abcd, 7);
    checkOutput("preResetErr", err_count, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("resetMidRun", {abcd, busy, done, pass, err_count, first_fail_valid, first_fail_vec}, 0);
    repeat (3) tick();
    checkOutput("idleAfterReset", {busy, done, abcd}, 0);
    applyStimulus(runTable[0]);

    // Reset and start on the same edge: reset wins
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    checkOutput("resetBeatsStart", {busy, done, pass, abcd, err_count}, 0);
    repeat (2) tick();
    checkOutput("stillIdle", {busy, done}, 0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
